// File: rtl/rom_fetch_arbiter.sv
// rom_fetch_arbiter: shares one SDRAM toggle-handshake read port between two
// CPU ROM fetch paths. Each CPU has a one-word cache. New requests stop, and
// the caches are flushed, while a ROM download is active.
module rom_fetch_arbiter #(
  parameter int unsigned      ADDR_W    = 15,
  parameter int unsigned      SD_AW     = 23,
  parameter logic [SD_AW-1:0] CPU1_BASE = 23'h00000,
  parameter logic [SD_AW-1:0] CPU2_BASE = 23'h08000
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              dl_active,
  input  logic              cpu1_cs,
  input  logic [ADDR_W-1:0] cpu1_addr,
  output logic [15:0]       cpu1_q,
  output logic              cpu1_valid,
  input  logic              cpu2_cs,
  input  logic [ADDR_W-1:0] cpu2_addr,
  output logic [15:0]       cpu2_q,
  output logic              cpu2_valid,
  output logic              sd_req,
  input  logic              sd_ack,
  output logic [SD_AW-1:0]  sd_addr,
  input  logic [15:0]       sd_q
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic                sd_req_q, sd_req_d;
  logic [SD_AW-1:0]    sd_addr_q, sd_addr_d;
  // Grant encoding: 0 = CPU1, 1 = CPU2
  logic                last_grant_q, last_grant_d;
  logic                grant_q, grant_d;
  logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
  logic                dl_seen_q, dl_seen_d;

  logic [ADDR_W-1:0]   tag1_q, tag1_d, tag2_q, tag2_d;
  logic [15:0]         data1_q, data1_d, data2_q, data2_d;
  logic                tv1_q, tv1_d, tv2_q, tv2_d;

  logic                hit1, hit2, miss1, miss2;
  logic                pick2;
  logic [ADDR_W-1:0]   pick_addr;
  logic                drop_fill;

  // Cache lookup: hits come combinationally from the registered tags.
  always_comb begin
    hit1  = cpu1_cs & tv1_q & (tag1_q == cpu1_addr) & ~dl_active;
    hit2  = cpu2_cs & tv2_q & (tag2_q == cpu2_addr) & ~dl_active;
    miss1 = cpu1_cs & ~hit1 & ~dl_active;
    miss2 = cpu2_cs & ~hit2 & ~dl_active;
  end

  // Round robin: CPU2 wins when it misses alone, or on a tie when CPU1 was granted last.
  always_comb begin
    pick2     = miss2 & (~miss1 | ~last_grant_q);
    pick_addr = pick2 ? cpu2_addr : cpu1_addr;
  end

  // Next-state logic for the request FSM and both cache lines.
  always_comb begin
    state_d      = state_q;
    sd_req_d     = sd_req_q;
    sd_addr_d    = sd_addr_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    pend_addr_d  = pend_addr_q;
    dl_seen_d    = dl_seen_q;
    tag1_d       = tag1_q;
    tag2_d       = tag2_q;
    data1_d      = data1_q;
    data2_d      = data2_q;
    tv1_d        = tv1_q;
    tv2_d        = tv2_q;
    drop_fill    = dl_seen_q | dl_active;

    if (dl_active) begin
      tv1_d = 1'b0;
      tv2_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (miss1 | miss2) begin
          sd_req_d     = ~sd_req_q;
          sd_addr_d    = (pick2 ? CPU2_BASE : CPU1_BASE) + SD_AW'(pick_addr);
          pend_addr_d  = pick_addr;
          grant_d      = pick2;
          last_grant_d = pick2;
          dl_seen_d    = 1'b0;
          state_d      = ST_WAIT;
        end
      end
      ST_WAIT: begin
        dl_seen_d = drop_fill;
        if (sd_ack == sd_req_q) begin
          state_d = ST_IDLE;
          // A download seen during the wait makes the returned word untrustworthy.
          if (!drop_fill) begin
            if (grant_q) begin
              data2_d = sd_q;
              tag2_d  = pend_addr_q;
              tv2_d   = 1'b1;
            end else begin
              data1_d = sd_q;
              tag1_d  = pend_addr_q;
              tv1_d   = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      sd_req_q     <= 1'b0;
      sd_addr_q    <= '0;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      pend_addr_q  <= '0;
      dl_seen_q    <= 1'b0;
      tag1_q       <= '0;
      tag2_q       <= '0;
      data1_q      <= '0;
      data2_q      <= '0;
      tv1_q        <= 1'b0;
      tv2_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sd_req_q     <= sd_req_d;
      sd_addr_q    <= sd_addr_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      pend_addr_q  <= pend_addr_d;
      dl_seen_q    <= dl_seen_d;
      tag1_q       <= tag1_d;
      tag2_q       <= tag2_d;
      data1_q      <= data1_d;
      data2_q      <= data2_d;
      tv1_q        <= tv1_d;
      tv2_q        <= tv2_d;
    end
  end

  assign cpu1_q     = data1_q;
  assign cpu2_q     = data2_q;
  assign cpu1_valid = hit1;
  assign cpu2_valid = hit2;
  assign sd_req     = sd_req_q;
  assign sd_addr    = sd_addr_q;

endmodule
